fib_sched: RTL and testbench

FIB_SCHED -- requirements
Module: fib_sched

---
 rtl/fib_sched_pkg.sv | 15 +
 rtl/fib_step_core.sv | 56 +++++
 rtl/fib_sched.sv | 112 +++++++++++
 tb/tb_fib_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_sched_pkg.sv
// Shared types and default sizes for the Fibonacci term scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fib_sched_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fib_step_core.sv
// Fibonacci pair register {a,b} = {F(k),F(k+1)} with sticky overflow flags and shared adders.
// Latency: one step (or two when dbl) per cycle with step high; load takes one cycle.
// Backpressure: none; the owner only asserts step while it wants the pair to advance.
module fib_step_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             dbl,
    output logic [WIDTH-1:0] a,
    output logic             oa
);

    logic [WIDTH-1:0] b;
    logic             ob;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic             c1;
    logic             c2;

    // s1 = a+b is the next b for a single step; s2 = b+s1 = a+2b is the second step.
    always_comb begin
        {c1, s1} = {1'b0, a} + {1'b0, b};
        {c2, s2} = {1'b0, b} + {1'b0, s1};
    end

    // Pair and flags shift together so oa always describes the value held in a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a  <= '0;
            b  <= '0;
            oa <= 1'b0;
            ob <= 1'b0;
        end else if (load) begin
            a  <= WIDTH'(1);
            b  <= WIDTH'(1);
            oa <= 1'b0;
            ob <= 1'b0;
        end else if (step) begin
            if (dbl) begin
                a  <= s1;
                b  <= s2;
                oa <= oa | ob | c1;
                ob <= oa | ob | c1 | c2;
            end else begin
                a  <= b;
                b  <= s1;
                oa <= ob;
                ob <= oa | ob | c1;
            end
        end
    end

endmodule

// File: rtl/fib_sched.sv
// Two-requester round-robin Fibonacci F(n) server over one shared step core; FIB_SCHED_DOUBLE_RATE_EN enables two steps per cycle.
// Latency: max(n-1,1) cycles accept-to-response (max(ceil((n-1)/2),1) with double rate).
// Backpressure: response held stable until rsp_rdy; req_rdy is low whenever not IDLE.
module fib_sched
    import fib_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_W   = DEF_N_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_vld,
    input  logic [N_W-1:0]   req_n0,
    input  logic [N_W-1:0]   req_n1,
    output logic [1:0]       req_rdy,
    output logic             rsp_vld,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    input  logic             rsp_rdy,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             id_q;
    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   rem;
    logic [N_W-1:0]   rem_dec;
    logic [N_W-1:0]   n_sel;
    logic             grant;
    logic             accept;
    logic             step;
    logic             dbl;
    logic [WIDTH-1:0] a;
    logic             oa;

    // Round-robin grant: the pointer only breaks ties, a lone requester always wins.
    always_comb begin
        grant   = ptr;
        req_rdy = 2'b00;
        if (req_vld == 2'b01) grant = 1'b0;
        else if (req_vld == 2'b10) grant = 1'b1;
        if (state == IDLE && req_vld[grant]) req_rdy[grant] = 1'b1;
        accept = |req_rdy;
        n_sel  = grant ? req_n1 : req_n0;
    end

    // Step control; the last odd step stays single so the pair lands exactly on F(n).
    always_comb begin
        step = (state == CALC);
`ifdef FIB_SCHED_DOUBLE_RATE_EN
        dbl  = step && (rem >= N_W'(2));
`else
        dbl  = 1'b0;
`endif
        rem_dec = rem - (dbl ? N_W'(2) : N_W'(1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (n_sel >= N_W'(2)) ? CALC : RESP;
            CALC: if (rem_dec == '0) state_nxt = RESP;
            RESP: if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer, request capture and remaining-step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            id_q  <= 1'b0;
            n_q   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id_q <= grant;
                n_q  <= n_sel;
                rem  <= (n_sel >= N_W'(2)) ? n_sel - N_W'(1) : '0;
            end else if (step) begin
                rem  <= rem_dec;
            end
            if (state == RESP && rsp_rdy) ptr <= ~id_q;
        end
    end

    fib_step_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (step),
        .dbl  (dbl),
        .a    (a),
        .oa   (oa)
    );

    // Response outputs are forced to zero outside RESP; n=0 reports F(0) rather than the loaded a=1.
    always_comb begin
        rsp_vld  = (state == RESP);
        rsp_id   = rsp_vld & id_q;
        rsp_data = (rsp_vld && n_q != '0) ? a : '0;
        rsp_ovf  = rsp_vld & oa;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched: latency, data, overflow, arbitration, stall and reset.
// Latency: expected accept-to-response counts derived from n and the rate macro.
// Backpressure: rsp_rdy held high except in the stall scenario.
module tb_fib_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_vld;
    logic [5:0]  req_n0;
    logic [5:0]  req_n1;
    logic [1:0]  req_rdy;
    logic        rsp_vld;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_ovf;
    logic        rsp_rdy;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fib_sched dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_n0   (req_n0),
        .req_n1   (req_n1),
        .req_rdy  (req_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_ovf  (rsp_ovf),
        .rsp_rdy  (rsp_rdy),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges after the accept edge until rsp_vld is visible. For n<=1 the response is
    // visible right after the accept edge, so its first handshake edge is one cycle later.
    function automatic int exp_lat(input int n);
`ifdef FIB_SCHED_DOUBLE_RATE_EN
        return (n <= 1) ? 0 : n / 2;
`else
        return (n <= 1) ? 0 : n - 1;
`endif
    endfunction

    // Wait (bounded) for rsp_vld, sampling #1 after each posedge; returns edge count.
    task automatic wait_rsp(output int cnt);
        cnt = 0;
        while (!rsp_vld && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    task automatic run_req(input int id, input int n, input logic [15:0] ed, input logic eo);
        int cnt;
        @(negedge clk);
        req_vld = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) req_n0 = 6'(n); else req_n1 = 6'(n);
        #1;
        checks++;
        if (req_rdy !== req_vld) begin
            errors++;
            $display("FAIL grant n=%0d: req_rdy=%b expected %b", n, req_rdy, req_vld);
        end
        @(posedge clk); #1;
        req_vld = 2'b00;
        wait_rsp(cnt);
        checks++;
        if (cnt !== exp_lat(n)) begin
            errors++;
            $display("FAIL latency n=%0d: got %0d expected %0d", n, cnt, exp_lat(n));
        end
        checks++;
        if (rsp_vld !== 1'b1 || rsp_data !== ed || rsp_ovf !== eo || rsp_id !== 1'(id) || busy !== 1'b1) begin
            errors++;
            $display("FAIL response n=%0d: vld=%b data=%0d ovf=%b id=%b busy=%b expected 1 %0d %b %0d 1",
                     n, rsp_vld, rsp_data, rsp_ovf, rsp_id, busy, ed, eo, id);
        end
        checks++;
        if (req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL resp_rdy_low n=%0d: req_rdy=%b expected 00", n, req_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release n=%0d: vld=%b busy=%b expected 0 0", n, rsp_vld, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 2'b00; req_n0 = '0; req_n1 = '0; rsp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_vld, rsp_id, rsp_data, rsp_ovf, busy, req_rdy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: vld=%b id=%b data=%0d ovf=%b busy=%b rdy=%b expected all 0",
                     rsp_vld, rsp_id, rsp_data, rsp_ovf, busy, req_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_req(0, 10, 16'd55, 1'b0);
        run_req(1, 0, 16'd0, 1'b0);
        run_req(0, 1, 16'd1, 1'b0);
        run_req(1, 2, 16'd1, 1'b0);
        run_req(0, 3, 16'd2, 1'b0);
    endtask

    task automatic test_overflow();
        run_req(0, 24, 16'd46368, 1'b0);
        run_req(1, 25, 16'd9489, 1'b1);
        run_req(0, 26, 16'd55857, 1'b1);  // 121393 - 65536
    endtask

    task automatic test_arbitration();
        int cnt;
        // Pointer is 0 right after reset.
        @(negedge clk);
        req_vld = 2'b11; req_n0 = 6'd5; req_n1 = 6'd6;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL arb_first: req_rdy=%b expected 01", req_rdy);
        end
        @(posedge clk); #1;
        // Keep both requesting; changing n0 mid-compute must not disturb the result.
        req_n0 = 6'd9;
        checks++;
        if (req_rdy !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arb_calc_rdy: req_rdy=%b busy=%b expected 00 1", req_rdy, busy);
        end
        wait_rsp(cnt);
        checks++;
        if (rsp_data !== 16'd5 || rsp_id !== 1'b0 || cnt !== exp_lat(5)) begin
            errors++;
            $display("FAIL arb_rsp0: data=%0d id=%b lat=%0d expected 5 0 %0d", rsp_data, rsp_id, cnt, exp_lat(5));
        end
        @(posedge clk); #1;
        // Back in IDLE with both valid: pointer now favours requester 1.
        checks++;
        if (req_rdy !== 2'b10) begin
            errors++;
            $display("FAIL arb_second: req_rdy=%b expected 10", req_rdy);
        end
        @(posedge clk); #1;
        req_vld = 2'b00;
        wait_rsp(cnt);
        checks++;
        if (rsp_data !== 16'd8 || rsp_id !== 1'b1 || cnt !== exp_lat(6)) begin
            errors++;
            $display("FAIL arb_rsp1: data=%0d id=%b lat=%0d expected 8 1 %0d", rsp_data, rsp_id, cnt, exp_lat(6));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int cnt;
        logic [15:0] d0;
        rsp_rdy = 1'b0;
        @(negedge clk);
        req_vld = 2'b01; req_n0 = 6'd7;
        @(posedge clk); #1;
        req_vld = 2'b10; req_n1 = 6'd4;  // waiting requester must not be granted
        wait_rsp(cnt);
        d0 = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== 16'd13 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0 ||
                busy !== 1'b1 || req_rdy !== 2'b00 || rsp_data !== d0) begin
                errors++;
                $display("FAIL stall_%0d: vld=%b data=%0d id=%b ovf=%b busy=%b rdy=%b expected 1 13 0 0 1 00",
                         i, rsp_vld, rsp_data, rsp_id, rsp_ovf, busy, req_rdy);
            end
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        req_vld = 2'b00;
        checks++;
        if (rsp_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: vld=%b busy=%b expected 0 0", rsp_vld, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        // Requester 0 was served last, so the pointer currently favours requester 1.
        @(negedge clk);
        req_vld = 2'b01; req_n0 = 6'd20;
        @(posedge clk); #1;
        req_vld = 2'b00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_vld, rsp_id, rsp_data, rsp_ovf, busy, req_rdy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid: vld=%b id=%b data=%0d ovf=%b busy=%b rdy=%b expected all 0",
                     rsp_vld, rsp_id, rsp_data, rsp_ovf, busy, req_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rsp_vld || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard: active cycles=%0d expected 0", seen);
        end
        @(negedge clk);
        req_vld = 2'b11; req_n0 = 6'd7; req_n1 = 6'd8;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL reset_ptr: req_rdy=%b expected 01", req_rdy);
        end
        req_vld = 2'b00;
        run_req(0, 7, 16'd13, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_basic();
        test_overflow();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
